// File: rtl/rf_access_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: FSM states,
// the hard-wired zero register index and the default starvation limit.
package rf_access_arbiter_pkg;

  localparam int unsigned ARB_DATA_W           = 32;
  localparam int unsigned ARB_ADDR_W           = 5;
  localparam int unsigned ARB_CNT_W            = 3;
  localparam int unsigned ARB_STARVE_LIMIT_DEF = 4;

  localparam logic [ARB_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_SERVE = 2'd1,
    ARB_STALL = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rf_arb_starve_cnt.sv
// Saturating counter of CPU-won cycles while a debug write waits; limit_hit_c
// flags the cycle whose increment reaches LIMIT.
module rf_arb_starve_cnt #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic limit_hit_c
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign limit_hit_c = inc && (cnt_d == LIMIT_V);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares the register-file write port between CPU writeback and a debug
// requester; CPU wins, but a starved debug write eventually forces a stall.
module rf_access_arbiter
  import rf_access_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = ARB_DATA_W,
  parameter int unsigned ADDR_W       = ARB_ADDR_W,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = ARB_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_dbg_raddr,
  input  logic [DATA_W-1:0] rf_dbg_rdata
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  arb_state_e        state_q, state_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              cnt_clear;
  logic              cnt_inc;
  logic              limit_hit_c;
  logic              dbg_sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rf_arb_starve_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clock       (clock),
    .reset       (reset),
    .clear       (cnt_clear),
    .inc         (cnt_inc),
    .limit_hit_c (limit_hit_c)
  );

  // Next-state, request latch, read capture and write-port select
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    dbg_sel     = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (dbg_req) begin
          req_we_d    = dbg_we;
          req_addr_d  = dbg_addr;
          req_wdata_d = dbg_wdata;
          cnt_clear   = 1'b1;
          state_d     = ARB_SERVE;
        end
      end
      ARB_SERVE: begin
        if (!req_we_q) begin
          // Same-cycle CPU write to the read target is forwarded
          if (req_addr_q == ZERO_IDX) begin
            rdata_d = '0;
          end else if (cpu_we && (cpu_waddr == req_addr_q)) begin
            rdata_d = cpu_wdata;
          end else begin
            rdata_d = rf_dbg_rdata;
          end
          state_d = ARB_ACK;
        end else if (!cpu_we) begin
          dbg_sel = 1'b1;
          state_d = ARB_ACK;
        end else begin
          cnt_inc = 1'b1;
          if (limit_hit_c) begin
            state_d = ARB_STALL;
          end
        end
      end
      ARB_STALL: begin
        dbg_sel = 1'b1;
        state_d = ARB_ACK;
      end
      ARB_ACK: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (dbg_sel) begin
      sel_we   = 1'b1;
      sel_addr = req_addr_q;
      sel_data = req_wdata_q;
    end else begin
      sel_we   = cpu_we;
      sel_addr = cpu_waddr;
      sel_data = cpu_wdata;
    end
  end

  assign rf_we        = sel_we && (sel_addr != ZERO_IDX);
  assign rf_waddr     = sel_addr;
  assign rf_wdata     = sel_data;
  assign rf_dbg_raddr = req_addr_q;
  assign dbg_rdata    = rdata_q;
  assign cpu_stall    = (state_q == ARB_STALL);
  assign dbg_ack      = (state_q == ARB_ACK);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Scoreboard bench for rf_access_arbiter: expected RF writes and debug acks are
// queued by the stimulus and popped by a negedge monitor.
module tb_rf_access_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_we;
  logic [4:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_dbg_raddr;
  logic [31:0] rf_dbg_rdata;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        chk;
    logic [31:0] rdata;
  } ack_t;

  wr_t  wr_q[$];
  ack_t ack_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cycles = 0;
  logic mon_en = 1'b0;

  logic [31:0] rf_model [32];

  rf_access_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .STARVE_LIMIT (4),
    .CNT_W        (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_we       (cpu_we),
    .cpu_waddr    (cpu_waddr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_rdata    (dbg_rdata),
    .dbg_ack      (dbg_ack),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_dbg_raddr (rf_dbg_raddr),
    .rf_dbg_rdata (rf_dbg_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model; r0 reads garbage so the arbiter's zero forcing is visible
  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
  end
  always @(posedge clock) begin
    if (rf_we) rf_model[rf_waddr] <= rf_wdata;
  end
  assign rf_dbg_rdata = (rf_dbg_raddr == 5'd0) ? 32'hBAD0_BAD0 : rf_model[rf_dbg_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every RF write and every ack must match the head of its queue
  always @(negedge clock) begin
    if (mon_en) begin
      if (cpu_stall) stall_cycles++;
      if (rf_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_rf_write_addr", 32'(rf_waddr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
          chk("rf_wdata", rf_wdata, e.data);
        end
      end
      if (dbg_ack) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_dbg_ack", 32'(dbg_ack), 32'h0);
        end else begin
          ack_t a;
          a = ack_q.pop_front();
          if (a.chk) chk("dbg_rdata", dbg_rdata, a.rdata);
        end
      end
    end
  end

  task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) wr_q.push_back('{addr: a, data: d});
    cpu_we    = 1'b1;
    cpu_waddr = a;
    cpu_wdata = d;
    tick();
    cpu_we    = 1'b0;
  endtask

  task automatic dbg_txn(input logic we, input logic [4:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, output int lat);
    ack_q.push_back('{chk: !we, rdata: exp_rd});
    if (we && (a != 5'd0)) wr_q.push_back('{addr: a, data: wd});
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = wd;
    dbg_req   = 1'b1;
    lat       = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dbg_ack) begin
        lat = i;
        break;
      end
    end
    dbg_req = 1'b0;
    if (lat < 0) chk("dbg_ack_timeout", 32'h0, 32'h1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic prev;
    int stall_at;
    int ack_at;
    int t1;
    int t2;

    reset = 1'b1;
    cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) tick();
    chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk("rst_rf_dbg_raddr", 32'(rf_dbg_raddr), 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Uncontended debug write, then read it back
    dbg_txn(1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0, lat);
    chk("wr_uncontended_latency", 32'(lat), 32'd2);
    dbg_txn(1'b0, 5'd5, 32'h0, 32'hDEAD_BEEF, lat);
    chk("rd_r5_latency", 32'(lat), 32'd2);

    // Read with same-cycle CPU write forwarding
    cpu_write(5'd7, 32'h11);
    ack_q.push_back('{chk: 1'b1, rdata: 32'h22});
    wr_q.push_back('{addr: 5'd7, data: 32'h22});
    dbg_we = 1'b0; dbg_addr = 5'd7; dbg_req = 1'b1;
    tick();
    cpu_we = 1'b1; cpu_waddr = 5'd7; cpu_wdata = 32'h22;
    tick();
    cpu_we = 1'b0;
    chk("fwd_ack", 32'(dbg_ack), 32'h1);
    dbg_req = 1'b0;
    tick();
    chk("fwd_rdata_held", dbg_rdata, 32'h22);

    // Starvation: CPU writes r3 every cycle, debug write r9 forces one stall
    for (int i = 0; i < 5; i++) wr_q.push_back('{addr: 5'd3, data: 32'h100 + 32'(i)});
    wr_q.push_back('{addr: 5'd9, data: 32'hCAFE});
    wr_q.push_back('{addr: 5'd3, data: 32'h105});
    ack_q.push_back('{chk: 1'b0, rdata: 32'h0});
    cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h100;
    dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hCAFE; dbg_req = 1'b1;
    n = 0; prev = 1'b0; stall_at = -1; ack_at = -1;
    for (int c = 1; c <= 12 && ack_at < 0; c++) begin
      tick();
      if (!prev) n++;
      cpu_wdata = 32'h100 + 32'(n);
      prev = cpu_stall;
      if (cpu_stall) begin
        stall_at = c;
        chk("stall_rf_waddr", 32'(rf_waddr), 32'd9);
      end
      if (dbg_ack) begin
        ack_at = c;
        dbg_req = 1'b0;
      end
    end
    tick();
    cpu_we = 1'b0;
    chk("starve_stall_cycle", 32'(stall_at), 32'd5);
    chk("starve_ack_cycle", 32'(ack_at), 32'd6);
    tick();

    // Zero register: debug write/read of r0 and a CPU write to r0
    dbg_txn(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, lat);
    chk("r0_write_latency", 32'(lat), 32'd2);
    dbg_txn(1'b0, 5'd0, 32'h0, 32'h0, lat);
    chk("r0_read_latency", 32'(lat), 32'd2);
    cpu_we = 1'b1; cpu_waddr = 5'd0; cpu_wdata = 32'h1234;
    #1;
    chk("cpu_r0_rf_we", 32'(rf_we), 32'h0);
    tick();
    cpu_we = 1'b0;

    // Reset during STALL drops the request; held req is re-served afterwards
    for (int i = 0; i < 5; i++) wr_q.push_back('{addr: 5'd3, data: 32'h200 + 32'(i)});
    wr_q.push_back('{addr: 5'd10, data: 32'hBEEF});
    wr_q.push_back('{addr: 5'd10, data: 32'hBEEF});
    ack_q.push_back('{chk: 1'b0, rdata: 32'h0});
    cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h200;
    dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'hBEEF; dbg_req = 1'b1;
    n = 0; prev = 1'b0; stall_at = -1;
    for (int c = 1; c <= 12 && stall_at < 0; c++) begin
      tick();
      if (!prev) n++;
      cpu_wdata = 32'h200 + 32'(n);
      prev = cpu_stall;
      if (cpu_stall) stall_at = c;
      if (dbg_ack) chk("rst_test_early_ack", 32'(dbg_ack), 32'h0);
    end
    chk("rst_test_stall_cycle", 32'(stall_at), 32'd5);
    reset = 1'b1;
    cpu_we = 1'b0;
    tick();
    chk("midrst_cpu_stall", 32'(cpu_stall), 32'h0);
    chk("midrst_dbg_ack", 32'(dbg_ack), 32'h0);
    chk("midrst_rf_dbg_raddr", 32'(rf_dbg_raddr), 32'h0);
    reset = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dbg_ack) begin
        lat = i;
        break;
      end
    end
    dbg_req = 1'b0;
    chk("reserve_after_reset_latency", 32'(lat), 32'd2);
    tick();

    // Back-to-back reads with dbg_req held high
    cpu_write(5'd1, 32'h1111);
    cpu_write(5'd2, 32'h2222);
    ack_q.push_back('{chk: 1'b1, rdata: 32'h1111});
    ack_q.push_back('{chk: 1'b1, rdata: 32'h2222});
    dbg_we = 1'b0; dbg_addr = 5'd1; dbg_req = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 1; i <= 20 && t2 < 0; i++) begin
      tick();
      if (dbg_ack) begin
        if (t1 < 0) begin
          t1 = i;
          dbg_addr = 5'd2;
        end else begin
          t2 = i;
        end
      end
    end
    dbg_req = 1'b0;
    chk("b2b_first_ack", 32'(t1), 32'd2);
    chk("b2b_ack_spacing", 32'(t2 - t1), 32'd3);
    repeat (2) tick();

    chk("total_stall_cycles", 32'(stall_cycles), 32'd2);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
